xsim_dma_burst_reader: RTL and testbench
========================================

Name: xsim_dma_burst_reader

Overview:
Burst read sequencer sitting directly upstream of the simulation DMA word port. Accepts one burst command (handle, start address, beat count, tag) and splits it into sequential 32-bit word read requests. Collects the one-deep read responses into a local FIFO and streams them to the consumer with tag and last flag. Used by xsim testbenches to give portal/memory clients a burst read interface over the word-at-a-time DPI memory model.

Parameters:
FIFO_DEPTH, 4, response buffer entries; power of 2, >= 2
LEN_WIDTH, 8, width of beat-count field
TAG_WIDTH, 8, width of command tag

Ports:
CLK  input  1  clock, all logic on posedge
RST  input  1  synchronous reset, active-high
cmd_valid  input  1  burst command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_handle  input  32  memory region handle
cmd_addr  input  32  byte address of first word
cmd_beats  input  LEN_WIDTH  number of 32-bit words; 0 means 2^LEN_WIDTH
cmd_tag  input  TAG_WIDTH  returned with every output beat
dma_rdy_readrequest  input  1  downstream can take a word request
dma_en_readrequest  output  1  issue word request this cycle
dma_readrequest_addr  output  32  word request address
dma_readrequest_handle  output  32  word request handle
dma_rdy_readresponse  input  1  downstream holds a valid response
dma_en_readresponse  output  1  pop downstream response this cycle
dma_readresponse_data  input  32  downstream response word
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts beat
out_data  output  32  read word
out_tag  output  TAG_WIDTH  tag of owning command
out_last  output  1  final beat of burst
busy  output  1  state != IDLE

Behaviour:
- Reset (RST=1 at posedge): state IDLE, FIFO empty, pending=0, counters 0; outputs cmd_ready=1, dma_en_readrequest=0, dma_en_readresponse=0, out_valid=0, out_last=0, busy=0, addr/handle/tag regs 0. Reset mid-burst drops all in-flight data; no beats emitted afterwards for that command. Downstream model shares RST, so its response register is cleared simultaneously.
- States: IDLE -> ISSUE on command accept; ISSUE -> DRAIN in the cycle the last word request issues; DRAIN -> IDLE in the cycle out_last beat is accepted (out_valid && out_ready && out_last) while pending==0.
- cmd_ready = (state==IDLE). Accept latches handle, addr, tag, remaining=beats (0 -> 2^LEN_WIDTH, held in LEN_WIDTH+1 bits), out_count=0.
- Issue rule: dma_en_readrequest = (state==ISSUE) && dma_rdy_readrequest && (fifo_count + pending < FIFO_DEPTH). Both counts are registered values; same-cycle pops do not add credit. On issue: addr += 4 (mod 2^32, wraps silently), remaining -= 1, pending += 1.
- Response rule: dma_en_readresponse = dma_rdy_readresponse (space is always reserved). On pop: push {data, last} into FIFO, pending -= 1. Simultaneous issue and pop: pending unchanged.
- last flag computed at push: received_count == total_beats-1.
- Output: out_valid = FIFO not empty; out_data/out_tag/out_last from head entry; pop on out_valid && out_ready. Simultaneous push and pop allowed at full/empty boundary without loss or bubble.
- Latency: first word request issues the cycle after command accept; first out_valid 2 cycles after first request (DMA model registers response, then FIFO write). Steady-state throughput 1 word/cycle with out_ready held high.
- FIFO overflow/underflow impossible by credit rule; assertion-worthy.
- New command not accepted until DRAIN completes (one burst in flight).

Optional Feature:
DMA_BURST_STATS_EN: when defined, adds outputs stat_words (32, words delivered on output since reset, wraps mod 2^32) and stat_stall_cycles (32, cycles with out_valid && !out_ready); both cleared by RST. When undefined, these ports and counters are absent; all other behaviour identical.

Test Plan:
- Single burst: handle=1, addr=0x100, beats=4, tag=0x5A, out_ready=1 -> requests at 0x100,0x104,0x108,0x10C on consecutive cycles; 4 beats of memory contents, tag 0x5A, out_last only on 4th; busy drops after.
- Backpressure: beats=16, out_ready=0 for 20 cycles -> exactly FIFO_DEPTH requests issued, then stall; release -> remaining 12 words in order, no loss/duplication.
- Wrap: addr=0xFFFFFFF8, beats=4 -> request addresses 0xFFFFFFF8,0xFFFFFFFC,0x00000000,0x00000004.
- beats=0 with LEN_WIDTH=8 -> exactly 256 beats, out_last on beat 256; cmd_ready low until accepted.
- Reset mid-burst: assert RST at 3rd output beat of 8-beat burst -> next cycle out_valid=0, cmd_ready=1, busy=0; next command runs cleanly from its own address.
- DMA_BURST_STATS_EN: two 4-beat bursts with 3 stall cycles -> stat_words=8, stat_stall_cycles=3.

Source files
------------

// File: rtl/xsim_dma_burst_reader.sv
// xsim_dma_burst_reader
//   Burst read sequencer in front of the simulation DMA word port. It accepts
//   one burst command (handle, byte address, beat count, tag) and splits it
//   into sequential 32-bit word read requests. Responses are collected into
//   a local FIFO and streamed to the consumer with the command tag and a
//   last-beat flag. Only one burst is in flight at a time.
//
// Ports:
//   CLK, RST                   clock (posedge) / synchronous active-high reset
//   cmd_*                      burst command handshake and fields
//                              (cmd_beats == 0 means 2^LEN_WIDTH words)
//   dma_*_readrequest*         word request channel to the DMA model
//   dma_*_readresponse*        one-deep response channel from the DMA model
//   out_*                      beat stream to the consumer (valid/ready)
//   busy                       a burst is being issued or drained
//
// Optional feature (macro DMA_BURST_STATS_EN):
//   stat_words          words delivered on the output since reset (wraps)
//   stat_stall_cycles   cycles with out_valid && !out_ready (wraps)

module xsim_dma_burst_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_handle,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_beats,
    input  logic [TAG_WIDTH-1:0] cmd_tag,
    input  logic                 dma_rdy_readrequest,
    output logic                 dma_en_readrequest,
    output logic [31:0]          dma_readrequest_addr,
    output logic [31:0]          dma_readrequest_handle,
    input  logic                 dma_rdy_readresponse,
    output logic                 dma_en_readresponse,
    input  logic [31:0]          dma_readresponse_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_last,
    output logic                 busy
`ifdef DMA_BURST_STATS_EN
    ,
    output logic [31:0]          stat_words,
    output logic [31:0]          stat_stall_cycles
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]        DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]        ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0]      ONE_PTR  = AW'(1);
    localparam logic [LEN_WIDTH:0] ONE_BEAT = (LEN_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [31:0]          handle_q;
    logic [31:0]          addr_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [LEN_WIDTH:0]   remaining;
    logic [LEN_WIDTH:0]   total_beats;
    logic [LEN_WIDTH:0]   recv_count;
    logic [AW:0]          pending;
    logic [AW:0]          fifo_count;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [32:0]          fifo_mem [FIFO_DEPTH];

    logic accept, issue, push, pop, credit_ok, push_last;

    // Credit uses registered counts only: responses popped this cycle do not
    // free space until the next cycle, so every issued request has a slot.
    always_comb begin
        accept    = (state == S_IDLE) && cmd_valid;
        credit_ok = ({1'b0, fifo_count} + {1'b0, pending}) < {1'b0, DEPTH_C};
        issue     = (state == S_ISSUE) && dma_rdy_readrequest && credit_ok;
        push      = dma_rdy_readresponse;
        push_last = (recv_count == (total_beats - ONE_BEAT));
        pop       = (fifo_count != '0) && out_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_ISSUE;
            S_ISSUE: if (issue && (remaining == ONE_BEAT)) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && fifo_mem[rd_ptr][0] && (pending == '0)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready              = (state == S_IDLE);
        busy                   = (state != S_IDLE);
        dma_en_readrequest     = issue;
        dma_readrequest_addr   = addr_q;
        dma_readrequest_handle = handle_q;
        dma_en_readresponse    = push;
        out_valid              = (fifo_count != '0);
        out_data               = fifo_mem[rd_ptr][32:1];
        out_last               = out_valid && fifo_mem[rd_ptr][0];
        // Tag only changes on accept, which needs an empty FIFO, so the
        // command register always matches the head entry's owner.
        out_tag                = tag_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            handle_q    <= '0;
            addr_q      <= '0;
            tag_q       <= '0;
            remaining   <= '0;
            total_beats <= '0;
            recv_count  <= '0;
            pending     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                handle_q    <= cmd_handle;
                addr_q      <= cmd_addr;
                tag_q       <= cmd_tag;
                remaining   <= {(cmd_beats == '0), cmd_beats};
                total_beats <= {(cmd_beats == '0), cmd_beats};
                recv_count  <= '0;
            end else if (issue) begin
                addr_q    <= addr_q + 32'd4;
                remaining <= remaining - ONE_BEAT;
            end

            case ({issue, push})
                2'b10:   pending <= pending + ONE_CNT;
                2'b01:   pending <= pending - ONE_CNT;
                default: pending <= pending;
            endcase

            if (push) begin
                wr_ptr     <= wr_ptr + ONE_PTR;
                recv_count <= recv_count + ONE_BEAT;
            end
            if (pop) rd_ptr <= rd_ptr + ONE_PTR;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + ONE_CNT;
                2'b01:   fifo_count <= fifo_count - ONE_CNT;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= {dma_readresponse_data, push_last};
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(push && !pop && (fifo_count == DEPTH_C)));
            assert (!(push && !issue && (pending == '0)));
        end
    end

`ifdef DMA_BURST_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_words        <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (pop) stat_words <= stat_words + 32'd1;
            if (out_valid && !out_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xsim_dma_burst_reader.sv
module tb_xsim_dma_burst_reader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned TAG_W = 8;
    localparam int          LOGN  = 300;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_handle = '0;
    logic [31:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_beats = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             dma_rdy_readrequest;
    logic             dma_en_readrequest;
    logic [31:0]      dma_readrequest_addr;
    logic [31:0]      dma_readrequest_handle;
    logic             dma_rdy_readresponse;
    logic             dma_en_readresponse;
    logic [31:0]      dma_readresponse_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_last;
    logic             busy;
`ifdef DMA_BURST_STATS_EN
    logic [31:0]      stat_words;
    logic [31:0]      stat_stall_cycles;
`endif

    xsim_dma_burst_reader #(
        .FIFO_DEPTH(DEPTH),
        .LEN_WIDTH (LEN_W),
        .TAG_WIDTH (TAG_W)
    ) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_handle             (cmd_handle),
        .cmd_addr               (cmd_addr),
        .cmd_beats              (cmd_beats),
        .cmd_tag                (cmd_tag),
        .dma_rdy_readrequest    (dma_rdy_readrequest),
        .dma_en_readrequest     (dma_en_readrequest),
        .dma_readrequest_addr   (dma_readrequest_addr),
        .dma_readrequest_handle (dma_readrequest_handle),
        .dma_rdy_readresponse   (dma_rdy_readresponse),
        .dma_en_readresponse    (dma_en_readresponse),
        .dma_readresponse_data  (dma_readresponse_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_data               (out_data),
        .out_tag                (out_tag),
        .out_last               (out_last),
        .busy                   (busy)
`ifdef DMA_BURST_STATS_EN
        ,
        .stat_words             (stat_words),
        .stat_stall_cycles      (stat_stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory contents seen through the word port.
    function automatic logic [31:0] mem_word(input logic [31:0] h, input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + (h << 24);
    endfunction

    // One-deep registered DMA response model sharing RST.
    logic        resp_valid;
    logic [31:0] resp_data;
    always @(posedge CLK) begin
        if (RST) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else if (dma_en_readrequest) begin
            resp_valid <= 1'b1;
            resp_data  <= mem_word(dma_readrequest_handle, dma_readrequest_addr);
        end else if (dma_en_readresponse) begin
            resp_valid <= 1'b0;
        end
    end
    assign dma_rdy_readresponse  = resp_valid;
    assign dma_readresponse_data = resp_data;
    assign dma_rdy_readrequest   = !resp_valid || dma_en_readresponse;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [31:0]      req_addr  [LOGN];
    int               req_cyc   [LOGN];
    int               req_n = 0;
    logic [31:0]      beat_data [LOGN];
    logic [TAG_W-1:0] beat_tag  [LOGN];
    logic             beat_last [LOGN];
    int               beat_cyc  [LOGN];
    int               beat_n = 0;

    // Handshakes sampled mid-cycle; they complete at the next posedge unless RST.
    always @(negedge CLK) begin
        if (!RST) begin
            if (dma_en_readrequest && req_n < LOGN) begin
                req_addr[req_n] = dma_readrequest_addr;
                req_cyc[req_n]  = cyc;
                req_n++;
            end
            if (out_valid && out_ready && beat_n < LOGN) begin
                beat_data[beat_n] = out_data;
                beat_tag[beat_n]  = out_tag;
                beat_last[beat_n] = out_last;
                beat_cyc[beat_n]  = cyc;
                beat_n++;
            end
        end
    end

    int tests = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        req_n  = 0;
        beat_n = 0;
    endtask

    task automatic send_cmd(input string name, input logic [31:0] h, input logic [31:0] a,
                            input logic [LEN_W-1:0] b, input logic [TAG_W-1:0] t);
        chk({name, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_handle = h;
        cmd_addr   = a;
        cmd_beats  = b;
        cmd_tag    = t;
        step(1);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        chk({name, "_idle"}, busy, 0);
    endtask

    task automatic check_burst(input string name, input logic [31:0] h, input logic [31:0] a0,
                               input int n, input logic [TAG_W-1:0] t);
        int bad_a = 0, bad_d = 0, bad_t = 0, bad_l = 0;
        chk({name, "_req_count"}, req_n, n);
        chk({name, "_beat_count"}, beat_n, n);
        for (int i = 0; i < n && i < LOGN; i++) begin
            if (req_addr[i] !== a0 + 32'(4 * i)) bad_a++;
            if (beat_data[i] !== mem_word(h, a0 + 32'(4 * i))) bad_d++;
            if (beat_tag[i] !== t) bad_t++;
            if (beat_last[i] !== (i == n - 1)) bad_l++;
        end
        chk({name, "_addr_errs"}, bad_a, 0);
        chk({name, "_data_errs"}, bad_d, 0);
        chk({name, "_tag_errs"}, bad_t, 0);
        chk({name, "_last_errs"}, bad_l, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, failed);
        $fatal(1);
    end

    initial begin
        int k;

        // Reset state
        step(3);
        RST = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_en_req", dma_en_readrequest, 0);
        chk("rst_en_resp", dma_en_readresponse, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_req_addr", dma_readrequest_addr, 0);
        chk("rst_req_handle", dma_readrequest_handle, 0);

        // Single 4-beat burst, consumer always ready
        clear_logs();
        out_ready = 1'b1;
        send_cmd("single", 32'd1, 32'h100, 8'd4, 8'h5A);
        chk("single_first_req_en", dma_en_readrequest, 1);
        chk("single_first_req_addr", dma_readrequest_addr, 32'h100);
        chk("single_first_req_handle", dma_readrequest_handle, 32'd1);
        chk("single_busy", busy, 1);
        chk("single_cmd_ready_low", cmd_ready, 0);
        wait_idle("single", 50);
        check_burst("single", 32'd1, 32'h100, 4, 8'h5A);
        chk("single_req_back_to_back", req_cyc[3] - req_cyc[0], 3);
        chk("single_first_out_latency", beat_cyc[0] - req_cyc[0], 2);
        chk("single_out_throughput", beat_cyc[3] - beat_cyc[0], 3);
        chk("single_cmd_ready_after", cmd_ready, 1);

        // Backpressure: only FIFO_DEPTH requests may be outstanding
        clear_logs();
        out_ready = 1'b0;
        send_cmd("bp", 32'd2, 32'h2000, 8'd16, 8'h33);
        step(20);
        chk("bp_reqs_while_stalled", req_n, DEPTH);
        chk("bp_beats_while_stalled", beat_n, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_no_issue", dma_en_readrequest, 0);
        chk("bp_head_data", out_data, mem_word(32'd2, 32'h2000));
        out_ready = 1'b1;
        wait_idle("bp", 200);
        check_burst("bp", 32'd2, 32'h2000, 16, 8'h33);

        // Address wrap past 2^32
        clear_logs();
        send_cmd("wrap", 32'd3, 32'hFFFF_FFF8, 8'd4, 8'h11);
        wait_idle("wrap", 50);
        chk("wrap_addr0", req_addr[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", req_addr[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", req_addr[2], 32'h0000_0000);
        chk("wrap_addr3", req_addr[3], 32'h0000_0004);
        check_burst("wrap", 32'd3, 32'hFFFF_FFF8, 4, 8'h11);

        // beats == 0 means 256 words
        clear_logs();
        send_cmd("max", 32'd4, 32'h4000, 8'd0, 8'hEE);
        step(50);
        chk("max_cmd_ready_mid", cmd_ready, 0);
        chk("max_busy_mid", busy, 1);
        wait_idle("max", 1000);
        check_burst("max", 32'd4, 32'h4000, 256, 8'hEE);

        // Reset while the 3rd beat of an 8-beat burst is on the output
        clear_logs();
        send_cmd("midrst", 32'd5, 32'h5000, 8'd8, 8'h77);
        k = 0;
        while (!(out_valid && beat_n == 2) && k < 50) begin
            step(1);
            k++;
        end
        chk("midrst_third_beat_seen", out_valid && beat_n == 2, 1);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        step(5);
        chk("midrst_no_more_beats", beat_n, 2);
        clear_logs();
        send_cmd("after", 32'd6, 32'h6000, 8'd3, 8'h42);
        wait_idle("after", 50);
        check_burst("after", 32'd6, 32'h6000, 3, 8'h42);

`ifdef DMA_BURST_STATS_EN
        // Two 4-beat bursts, the second held off for 3 cycles once valid
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("stats_reset_words", stat_words, 0);
        chk("stats_reset_stall", stat_stall_cycles, 0);
        out_ready = 1'b1;
        send_cmd("stats1", 32'd7, 32'h7000, 8'd4, 8'h01);
        wait_idle("stats1", 50);
        out_ready = 1'b0;
        send_cmd("stats2", 32'd7, 32'h8000, 8'd4, 8'h02);
        k = 0;
        while (!out_valid && k < 50) begin
            step(1);
            k++;
        end
        chk("stats_valid_seen", out_valid, 1);
        step(3);
        out_ready = 1'b1;
        wait_idle("stats2", 50);
        chk("stats_words", stat_words, 8);
        chk("stats_stall", stat_stall_cycles, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
